// File: rtl/coloring_gen.sv
// Colour-stream generator: forwards requested colours and inserts one filler
// whenever a request would violate the downstream checker's sequence rules.
module coloring_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_color,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_color,
  output logic [3:0] hist,
  output logic [1:0] hcnt,
  output logic [7:0] ins_cnt
);

  typedef enum logic [1:0] {IDLE, OUT, FILL} state_e;

  state_e     state_q;
  logic       out_valid_q;
  logic [1:0] out_color_q, pend_q, hcnt_q, hcnt_d;
  logic [3:0] hist_q, hist_d;
  logic [7:0] ins_cnt_q;

  logic       accept, illegal, commit_en;
  logic [1:0] filler, commit_color;

  assign in_ready = (state_q == IDLE) || (state_q == OUT && out_ready);
  assign accept   = in_valid && in_ready;
  assign filler   = (in_color == 2'b10) ? 2'b11 : 2'b10;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    illegal = 1'b0;
    if (hcnt_q >= 2'd2 && hist_q[3:2] == in_color && hist_q[1:0] == in_color)
      illegal = 1'b1;
    if (hcnt_q >= 2'd1 &&
        ((hist_q[1:0] == 2'b00 && in_color == 2'b01) ||
         (hist_q[1:0] == 2'b01 && in_color == 2'b00)))
      illegal = 1'b1;
  end

  // At most one commit per cycle: an accept, or the pending colour leaving FILL.
  always_comb begin
    commit_en    = 1'b0;
    commit_color = in_color;
    if (accept) begin
      commit_en    = 1'b1;
      commit_color = illegal ? filler : in_color;
    end else if (state_q == FILL && out_ready) begin
      commit_en    = 1'b1;
      commit_color = pend_q;
    end
    hist_d = commit_en ? {hist_q[1:0], commit_color} : hist_q;
    hcnt_d = (commit_en && hcnt_q != 2'd3) ? hcnt_q + 2'd1 : hcnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_color_q <= 2'b00;
      pend_q      <= 2'b00;
      hist_q      <= 4'b0000;
      hcnt_q      <= 2'd0;
      ins_cnt_q   <= 8'd0;
    end else begin
      hist_q <= hist_d;
      hcnt_q <= hcnt_d;
      case (state_q)
        IDLE, OUT: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_color_q <= commit_color;
            if (illegal) begin
              pend_q  <= in_color;
              state_q <= FILL;
              if (ins_cnt_q != 8'hFF) ins_cnt_q <= ins_cnt_q + 8'd1;
            end else begin
              state_q <= OUT;
            end
          end else if (state_q == OUT && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        FILL: begin
          if (out_ready) begin
            out_color_q <= pend_q;
            state_q     <= OUT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_color = out_color_q;
  assign hist      = hist_q;
  assign hcnt      = hcnt_q;
  assign ins_cnt   = ins_cnt_q;

endmodule

// File: tb/tb_coloring_gen.sv
// Self-checking bench for coloring_gen: scoreboard of expected emitted colours
// plus an independent checker model on the output stream.
module tb_coloring_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_color = 2'b00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [1:0] out_color, hcnt;
  logic [3:0] hist;
  logic [7:0] ins_cnt;

  coloring_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_color  (in_color),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_color (out_color),
    .hist      (hist),
    .hcnt      (hcnt),
    .ins_cnt   (ins_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic breaks(input logic [3:0] h, input logic [1:0] n, input logic [1:0] c);
    return (n >= 2'd2 && h[3:2] == c && h[1:0] == c) ||
           (n >= 2'd1 && ((h[1:0] == 2'b00 && c == 2'b01) || (h[1:0] == 2'b01 && c == 2'b00)));
  endfunction

  typedef struct packed {
    logic [1:0] col;
    logic       fill;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_hist = '0;
  logic [1:0] m_hcnt = '0;
  logic [3:0] c_hist = '0;
  logic [1:0] c_hcnt = '0;
  int         fill_seen = 0;
  logic       acc_now = 1'b0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: all model state lives here; sampled mid-cycle, ahead of the edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] f;
    acc_now = in_valid && in_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_hist = '0; m_hcnt = '0;
      c_hist = '0; c_hcnt = '0;
      fill_seen = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("stream", out_color, e.col);
          if (e.fill) fill_seen++;
          check("checker_rule", breaks(c_hist, c_hcnt, out_color), 1'b0);
          c_hist = {c_hist[1:0], out_color};
          if (c_hcnt != 2'd3) c_hcnt++;
        end
      end
      if (acc_now) begin
        if (breaks(m_hist, m_hcnt, in_color)) begin
          f = (in_color == 2'b10) ? 2'b11 : 2'b10;
          exp_q.push_back('{col: f, fill: 1'b1});
          m_hist = {m_hist[1:0], f};
          if (m_hcnt != 2'd3) m_hcnt++;
        end
        exp_q.push_back('{col: in_color, fill: 1'b0});
        m_hist = {m_hist[1:0], in_color};
        if (m_hcnt != 2'd3) m_hcnt++;
      end
    end
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one request; returns just after the accepting edge.
  task automatic send(input logic [1:0] c, output int acc_cyc);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_color = c;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, a3, low, exp_ins;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_color", out_color, 2'b00);
    check("rst_hist", hist, 4'b0000);
    check("rst_hcnt", hcnt, 2'd0);
    check("rst_ins_cnt", ins_cnt, 8'd0);
    rst_n = 1'b1;
    #1 check("idle_in_ready", in_ready, 1'b1);

    // First colour 01 is legal straight after reset
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b01, a0);
    check("first_out_valid", out_valid, 1'b1);
    check("first_out_color", out_color, 2'b01);
    check("first_hist", hist, 4'b0001);
    check("first_hcnt", hcnt, 2'd1);
    check("first_ins_cnt", ins_cnt, 8'd0);
    idle(3);

    // 10,10,10 -> 10,10,11,10
    do_reset();
    out_ready = 1'b1;
    send(2'b10, a0);
    send(2'b10, a0);
    send(2'b10, a0);
    low = 0;
    repeat (4) begin
      @(negedge clk);
      if (!in_ready) low++;
    end
    check("fill_ready_low_cycles", low, 1);
    check("r1_hist", hist, 4'b1110);
    check("r1_hcnt", hcnt, 2'd3);
    check("r1_ins_cnt", ins_cnt, 8'd1);
    check("r1_drained", exp_q.size(), 0);

    // 00,01 -> 00,10,01; then 11,11 with no filler
    do_reset();
    out_ready = 1'b1;
    send(2'b00, a0);
    send(2'b01, a0);
    send(2'b11, a0);
    send(2'b11, a0);
    idle(4);
    check("r2_ins_cnt", ins_cnt, 8'd1);
    check("r2_hist", hist, 4'b1111);
    check("r2_drained", exp_q.size(), 0);

    // Backpressure holds the output, then back-to-back streaming
    do_reset();
    send(2'b00, a0);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_color", out_color, 2'b00);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hcnt", hcnt, 2'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b11, a0);
    send(2'b10, a1);
    send(2'b11, a2);
    send(2'b10, a3);
    check("throughput_cycles", a3 - a0, 3);
    idle(3);
    check("bp_ins_cnt", ins_cnt, 8'd0);
    check("bp_drained", exp_q.size(), 0);

    // Asynchronous reset while holding a filler
    do_reset();
    out_ready = 1'b1;
    send(2'b00, a0);
    send(2'b01, a0);
    out_ready = 1'b0;
    check("pre_rst_ins_cnt", ins_cnt, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_color", out_color, 2'b00);
    check("arst_hist", hist, 4'b0000);
    check("arst_hcnt", hcnt, 2'd0);
    check("arst_ins_cnt", ins_cnt, 8'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    low = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) low++;
    end
    check("pending_dropped", low, 0);

    // Random requests with random backpressure
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (acc_now || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_color = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check("rand_drained", exp_q.size(), 0);
    exp_ins = (fill_seen > 255) ? 255 : fill_seen;
    check("rand_ins_cnt", ins_cnt, exp_ins);
    check("rand_hcnt_sat", hcnt, 2'd3);
    check("rand_out_idle", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
